// File: rtl/counter_job_arbiter_if.sv
// Job request / completion bus between two requesters, the arbiter and the
// shared mod-2**W counter. The arbiter uses the slave view; the requester
// and counter side uses the master view.
interface counter_job_arbiter_if #(
  parameter int W = 4
);
  // requester 0/1 job fields, held while req is high
  logic         req0, req1;
  logic         dir0, dir1;
  logic [W-1:0] start0, start1;
  logic [W-1:0] target0, target1;
  logic         ack0, ack1;
  // cancel of the running job
  logic         abort;
  // counter side
  logic [W-1:0] cnt_value;
  logic         cnt_x;
  logic         cnt_preload;
  logic [W-1:0] cnt_load;
  // job status
  logic         busy;
  logic         owner;
  logic         done;
  logic         done_id;
  logic         timeout_err;

  modport master (
    output req0, req1, dir0, dir1, start0, start1, target0, target1,
    output abort, cnt_value,
    input  ack0, ack1, cnt_x, cnt_preload, cnt_load,
    input  busy, owner, done, done_id, timeout_err
  );

  modport slave (
    input  req0, req1, dir0, dir1, start0, start1, target0, target1,
    input  abort, cnt_value,
    output ack0, ack1, cnt_x, cnt_preload, cnt_load,
    output busy, owner, done, done_id, timeout_err
  );
endinterface

// File: rtl/counter_job_arbiter.sv
// Round-robin arbiter sharing one up/down counter between two requesters.
// A granted job preloads the counter, runs it in the requested direction and
// finishes on target match, abort or run-cycle timeout. All outputs are
// registered so reset clears them asynchronously.

// Per-requester acknowledge: one-cycle pulse in the cycle after the grant.
module counter_job_arbiter_lane (
  input  logic clkout,
  input  logic reset,
  input  logic grant,
  output logic ack
);
  // ack registers the grant decision made in IDLE
  always_ff @(posedge clkout or negedge reset) begin
    if (!reset) ack <= 1'b0;
    else        ack <= grant;
  end
endmodule

module counter_job_arbiter #(
  parameter int W       = 4,
  parameter int TIMEOUT = 18
) (
  input logic                  clkout,
  input logic                  reset,
  counter_job_arbiter_if.slave bus
);
  localparam int NUM_LANES = 2;
  localparam int RCW       = $clog2(TIMEOUT + 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_LOAD = 2'd1;
  localparam logic [1:0] S_RUN  = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  logic [1:0]                          state;
  logic [NUM_LANES-1:0]                req_v, dir_v, grant_v, ack_v;
  logic [NUM_LANES-1:0][W-1:0]         start_v, target_v;
  logic                                any_req, gnt;
  logic                                rr_pref;   // index preferred when both request
  logic [W-1:0]                        target_q;
  logic [RCW-1:0]                      run_cnt, run_inc;
  logic                                hit, run_tmo, run_end, grant_now;

  logic                                cnt_x_q, preload_q, busy_q, owner_q;
  logic                                done_q, done_id_q, tmo_q;
  logic [W-1:0]                        load_q;

  assign req_v    = {bus.req1, bus.req0};
  assign dir_v    = {bus.dir1, bus.dir0};
  assign start_v  = {bus.start1, bus.start0};
  assign target_v = {bus.target1, bus.target0};

  // grant selection: lone requester wins, contention goes to the preferred index
  always_comb begin
    any_req = |req_v;
    gnt     = 1'b0;
    if (&req_v) gnt = rr_pref;
    else        gnt = req_v[1];
  end

  assign grant_now = (state == S_IDLE) && any_req;

  // run-cycle count including the current RUN cycle, saturating at TIMEOUT
  assign run_inc = (run_cnt == RCW'(TIMEOUT)) ? run_cnt : run_cnt + RCW'(1);
  assign hit     = (bus.cnt_value == target_q);
  assign run_tmo = (run_inc == RCW'(TIMEOUT));
  assign run_end = hit || bus.abort || run_tmo;

  genvar i;
  generate
    for (i = 0; i < NUM_LANES; i++) begin : g_lane
      assign grant_v[i] = grant_now && (gnt == 1'(i));
      counter_job_arbiter_lane u_lane (
        .clkout (clkout),
        .reset  (reset),
        .grant  (grant_v[i]),
        .ack    (ack_v[i])
      );
    end
  endgenerate

  // run-cycle counter: cleared on grant, counts every RUN cycle
  always_ff @(posedge clkout or negedge reset) begin
    if (!reset)                run_cnt <= '0;
    else if (grant_now)        run_cnt <= '0;
    else if (state == S_RUN)   run_cnt <= run_inc;
  end

  // job FSM with registered counter controls and status outputs
  always_ff @(posedge clkout or negedge reset) begin
    if (!reset) begin
      state     <= S_IDLE;
      rr_pref   <= 1'b0;
      target_q  <= '0;
      cnt_x_q   <= 1'b0;
      preload_q <= 1'b0;
      load_q    <= '0;
      busy_q    <= 1'b0;
      owner_q   <= 1'b0;
      done_q    <= 1'b0;
      done_id_q <= 1'b0;
      tmo_q     <= 1'b0;
    end else begin
      done_q    <= 1'b0;
      preload_q <= 1'b0;
      case (state)
        S_IDLE: begin
          if (any_req) begin
            owner_q   <= gnt;
            busy_q    <= 1'b1;
            tmo_q     <= 1'b0;
            cnt_x_q   <= dir_v[gnt];
            load_q    <= start_v[gnt];
            target_q  <= target_v[gnt];
            preload_q <= 1'b1;
            state     <= S_LOAD;
          end
        end
        S_LOAD: state <= S_RUN;
        S_RUN: begin
          if (run_end) begin
            // target match outranks abort, abort outranks timeout
            tmo_q     <= !hit && !bus.abort;
            busy_q    <= 1'b0;
            done_q    <= 1'b1;
            done_id_q <= owner_q;
            state     <= S_DONE;
          end
        end
        default: begin
          // the requester just served loses the next contention
          rr_pref <= ~owner_q;
          state   <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.ack0        = ack_v[0];
  assign bus.ack1        = ack_v[1];
  assign bus.cnt_x       = cnt_x_q;
  assign bus.cnt_preload = preload_q;
  assign bus.cnt_load    = load_q;
  assign bus.busy        = busy_q;
  assign bus.owner       = owner_q;
  assign bus.done        = done_q;
  assign bus.done_id     = done_id_q;
  assign bus.timeout_err = tmo_q;
endmodule

// File: tb/tb_counter_job_arbiter.sv
// Scoreboard bench: drivers push expected grant/completion records, a
// negedge monitor pops and compares whenever ack or done appears. The bench
// also models the shared mod-16 counter, with a stall control.
module tb_counter_job_arbiter;
  typedef struct { int id; int load; int dir; } ack_exp_t;
  typedef struct { int id; int tmo; int lat; } done_exp_t;

  logic clkout = 1'b0;
  logic reset  = 1'b0;
  logic stall  = 1'b0;
  logic [3:0] cnt = 4'd0;
  int cyc = 0, n_checks = 0, n_err = 0, n_ack = 0, n_done = 0;
  int ack_cyc = 0, last_done_cyc = 0;
  bit have_done = 1'b0;
  ack_exp_t  ack_q[$];
  done_exp_t done_q[$];
  ack_exp_t  ae;
  done_exp_t de;

  counter_job_arbiter_if #(.W(4)) bus ();

  counter_job_arbiter #(.W(4), .TIMEOUT(18)) dut (
    .clkout (clkout),
    .reset  (reset),
    .bus    (bus)
  );

  always #5 clkout = ~clkout;
  always @(posedge clkout) cyc <= cyc + 1;

  // shared counter model
  always @(posedge clkout) begin
    if (bus.cnt_preload) cnt <= bus.cnt_load;
    else if (!stall)     cnt <= bus.cnt_x ? cnt + 4'd1 : cnt - 4'd1;
  end
  assign bus.cnt_value = cnt;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // monitor
  always @(negedge clkout) begin
    if (reset) begin
      if (bus.ack0 && bus.ack1) check("ack_both", 1, 0);
      if (bus.ack0 || bus.ack1) begin
        if (ack_q.size() == 0) check("ack_unexpected", 1, 0);
        else begin
          ae = ack_q.pop_front();
          check("ack_id", 32'(bus.ack1), ae.id);
          check("preload", 32'(bus.cnt_preload), 1);
          check("cnt_load", 32'(bus.cnt_load), ae.load);
          check("cnt_x", 32'(bus.cnt_x), ae.dir);
          check("busy_grant", 32'(bus.busy), 1);
          check("owner", 32'(bus.owner), ae.id);
          check("tmo_clear", 32'(bus.timeout_err), 0);
          if (have_done) check("idle_gap", 32'((cyc - last_done_cyc) >= 2), 1);
        end
        ack_cyc = cyc;
        n_ack++;
      end else if (bus.cnt_preload) check("preload_no_ack", 1, 0);
      if (bus.done) begin
        if (done_q.size() == 0) check("done_unexpected", 1, 0);
        else begin
          de = done_q.pop_front();
          check("done_id", 32'(bus.done_id), de.id);
          check("timeout_err", 32'(bus.timeout_err), de.tmo);
          check("latency", cyc - ack_cyc, de.lat);
          check("busy_done", 32'(bus.busy), 0);
        end
        last_done_cyc = cyc;
        have_done = 1'b1;
        n_done++;
      end
    end
  end

  task automatic outputs_zero(input string tag);
    check({tag, "_ack"}, {30'd0, bus.ack1, bus.ack0}, 0);
    check({tag, "_cnt_x"}, 32'(bus.cnt_x), 0);
    check({tag, "_preload"}, 32'(bus.cnt_preload), 0);
    check({tag, "_cnt_load"}, 32'(bus.cnt_load), 0);
    check({tag, "_busy"}, 32'(bus.busy), 0);
    check({tag, "_owner"}, 32'(bus.owner), 0);
    check({tag, "_done"}, {30'd0, bus.done_id, bus.done}, 0);
    check({tag, "_tmo"}, 32'(bus.timeout_err), 0);
  endtask

  task automatic wait_acks(input int k);
    int t = 0;
    while (n_ack < k && t < 200) begin @(posedge clkout); t++; end
    check("wait_ack", 32'(n_ack >= k), 1);
  endtask

  task automatic wait_dones(input int k);
    int t = 0;
    while (n_done < k && t < 200) begin @(posedge clkout); t++; end
    check("wait_done", 32'(n_done >= k), 1);
  endtask

  task automatic set_fields(input bit id, input bit d, input logic [3:0] s, input logic [3:0] tg);
    if (id) begin bus.dir1 = d; bus.start1 = s; bus.target1 = tg; end
    else    begin bus.dir0 = d; bus.start0 = s; bus.target0 = tg; end
  endtask

  task automatic push_exp(input bit id, input bit d, input int s, input int lat, input int tmo,
                          input bit with_done);
    ack_exp_t a;
    done_exp_t dd;
    a.id = id; a.load = s; a.dir = d;
    ack_q.push_back(a);
    if (with_done) begin
      dd.id = id; dd.tmo = tmo; dd.lat = lat;
      done_q.push_back(dd);
    end
  endtask

  // single-requester job: request, drop on ack, wait for completion
  task automatic run_job(input bit id, input bit d, input logic [3:0] s, input logic [3:0] tg,
                         input int lat, input int tmo);
    int ka, kd;
    ka = n_ack + 1; kd = n_done + 1;
    push_exp(id, d, 32'(s), lat, tmo, 1'b1);
    @(negedge clkout);
    set_fields(id, d, s, tg);
    if (id) bus.req1 = 1'b1; else bus.req0 = 1'b1;
    wait_acks(ka);
    @(negedge clkout);
    bus.req0 = 1'b0; bus.req1 = 1'b0;
    wait_dones(kd);
  endtask

  initial begin
    bus.req0 = 1'b0; bus.req1 = 1'b0; bus.abort = 1'b0;
    set_fields(1'b0, 1'b0, 4'd0, 4'd0);
    set_fields(1'b1, 1'b0, 4'd0, 4'd0);
    #3;
    outputs_zero("reset");

    // both requesters held from reset: 0,1,0,1 with an IDLE cycle between jobs
    set_fields(1'b0, 1'b1, 4'd2, 4'd4);
    set_fields(1'b1, 1'b0, 4'd8, 4'd6);
    bus.req0 = 1'b1; bus.req1 = 1'b1;
    for (int j = 0; j < 4; j++) begin
      if (j % 2 == 0) push_exp(1'b0, 1'b1, 2, 4, 0, 1'b1);
      else            push_exp(1'b1, 1'b0, 8, 4, 0, 1'b1);
    end
    @(negedge clkout);
    reset = 1'b1;
    wait_acks(4);
    @(negedge clkout);
    bus.req0 = 1'b0; bus.req1 = 1'b0;
    wait_dones(4);

    // count up 3 -> 7
    run_job(1'b0, 1'b1, 4'd3, 4'd7, 6, 0);
    // start equals target: earliest completion
    run_job(1'b0, 1'b0, 4'd9, 4'd9, 2, 0);
    // count down with wrap 1 -> 0 -> 15 -> 14
    run_job(1'b1, 1'b0, 4'd1, 4'd14, 5, 0);
    // stalled counter never reaches target: timeout after 18 RUN cycles
    stall = 1'b1;
    run_job(1'b1, 1'b1, 4'd5, 4'd6, 19, 1);
    stall = 1'b0;

    // abort in RUN cycle 2, target 9 unreached
    begin
      int ka, kd;
      ka = n_ack + 1; kd = n_done + 1;
      push_exp(1'b0, 1'b1, 0, 3, 0, 1'b1);
      @(negedge clkout);
      set_fields(1'b0, 1'b1, 4'd0, 4'd9);
      bus.req0 = 1'b1;
      wait_acks(ka);
      @(negedge clkout);          // RUN cycle 1
      bus.req0 = 1'b0;
      @(negedge clkout);          // RUN cycle 2
      bus.abort = 1'b1;
      @(negedge clkout);
      bus.abort = 1'b0;
      wait_dones(kd);
    end

    // reset during RUN: outputs clear at once, job lost, req0 wins next
    begin
      int ka, kd;
      ka = n_ack + 1;
      push_exp(1'b1, 1'b1, 0, 0, 0, 1'b0);
      @(negedge clkout);
      set_fields(1'b1, 1'b1, 4'd0, 4'd15);
      bus.req1 = 1'b1;
      wait_acks(ka);
      @(negedge clkout);
      bus.req1 = 1'b0;
      @(negedge clkout);
      @(negedge clkout);
      reset = 1'b0;
      #1;
      outputs_zero("midrun");
      check("busy_before_edge", 32'(bus.busy), 0);
      ka = n_ack + 1; kd = n_done + 1;
      push_exp(1'b0, 1'b1, 4, 3, 0, 1'b1);
      set_fields(1'b0, 1'b1, 4'd4, 4'd5);
      set_fields(1'b1, 1'b0, 4'd7, 4'd3);
      bus.req0 = 1'b1; bus.req1 = 1'b1;
      @(negedge clkout);
      reset = 1'b1;
      wait_acks(ka);
      @(negedge clkout);
      bus.req0 = 1'b0; bus.req1 = 1'b0;
      wait_dones(kd);
    end

    repeat (4) @(negedge clkout);
    check("ack_q_empty", ack_q.size(), 0);
    check("done_q_empty", done_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end
endmodule
